// File: rtl/adc_link_pkg.sv
// Shared constants and types for the serial ADC link (responder and controller wrappers).
package adc_link_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int NUM_CH     = 8;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int CFG_BITS   = 6;
    localparam int CNT_W      = 4;

    // Bit positions inside the 6-bit configuration word
    localparam int SD     = 5;
    localparam int CH_MSB = 4;
    localparam int CH_LSB = 2;
    localparam int UNI    = 1;
    localparam int SLP    = 0;

    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/adc_serial_responder_if.sv
// Four-wire ADC link: controller drives SCLK/CS_N/DIN, device drives DOUT.
interface adc_serial_responder_if;
    logic sclk;
    logic cs_n;
    logic din;
    logic dout;

    modport master (output sclk, cs_n, din, input dout);
    modport slave  (input sclk, cs_n, din, output dout);
endinterface

// File: rtl/adc_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection on the synced value.
module adc_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            dly   <= RST_VAL;
        end else begin
            chain <= (chain << 1) | SYNC_STAGES'(pin);
            dly   <= sync;
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;
endmodule

// File: rtl/adc_serial_responder.sv
// Device end of the pipelined serial ADC link: decodes the config word and returns the
// sample of the channel selected by the previous frame.
module adc_serial_responder
    import adc_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    adc_serial_responder_if.slave          link,
    output logic [CH_W-1:0]                cfg_channel,
    output logic                           frame_done,
    output logic                           frame_err
);
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic din_s, din_rise, din_fall;

    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin(link.sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .pin(link.cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
    adc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
        .clk(clk), .rst_n(rst_n), .pin(link.din), .sync(din_s), .rise(din_rise), .fall(din_fall));

    logic unused_pins;
    assign unused_pins = ^{sclk_s, cs_s, din_rise, din_fall};

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [CFG_BITS-1:0]   cfg, cfg_n;
    logic [CNT_W-1:0]      bit_cnt, cnt_n;
    logic                  dout_r, dout_n;
    logic [CH_W-1:0]       ch_n;
    logic                  done_n, err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            cfg         <= '0;
            bit_cnt     <= '0;
            dout_r      <= 1'b0;
            cfg_channel <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            cfg         <= cfg_n;
            bit_cnt     <= cnt_n;
            dout_r      <= dout_n;
            cfg_channel <= ch_n;
            frame_done  <= done_n;
            frame_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cfg_n   = cfg;
        cnt_n   = bit_cnt;
        dout_n  = dout_r;
        ch_n    = cfg_channel;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                dout_n = 1'b0;
                if (cs_fall) begin
                    // Sample is frozen here; later ch_data changes do not reach this frame
                    shift_n = ch_data[cfg_channel*DATA_WIDTH +: DATA_WIDTH];
                    dout_n  = shift_n[DATA_WIDTH-1];
                    cnt_n   = '0;
                    cfg_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    dout_n  = 1'b0;
                    if (bit_cnt >= CNT_W'(CFG_BITS) && cfg[SD]) begin
                        ch_n   = cfg[CH_MSB:CH_LSB];
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (!cs_fall) begin
                    // A CS_N edge in the same cycle swallows any SCLK edge
                    if (sclk_rise) begin
                        if (bit_cnt < CNT_W'(CFG_BITS))
                            cfg_n = {cfg[CFG_BITS-2:0], din_s};
                        if (bit_cnt != {CNT_W{1'b1}})
                            cnt_n = bit_cnt + 1'b1;
                    end else if (sclk_fall) begin
                        shift_n = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        dout_n  = shift_n[DATA_WIDTH-1];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign link.dout = dout_r;
endmodule

// File: tb/tb_adc_serial_responder.sv
// Randomized bench for adc_serial_responder against a frame-level model of the link.
module tb_adc_serial_responder;
    import adc_link_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] ch [8];
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [2:0] cfg_channel;
    logic frame_done, frame_err;

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = ch[k];
    end

    adc_serial_responder_if link();

    adc_serial_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .link(link),
        .cfg_channel(cfg_channel), .frame_done(frame_done), .frame_err(frame_err));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-end expectation: pulse kind and new channel, due at cycle pend_cyc
    int         pend_cyc = -10;
    logic       pend_ok = 1'b0;
    logic [2:0] pend_ch = '0;
    logic [2:0] exp_ch = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ch = '0;
            check("rst_dout", link.dout, 0);
            check("rst_done", frame_done, 0);
            check("rst_err", frame_err, 0);
            check("rst_ch", cfg_channel, 0);
        end else begin
            if (cyc == pend_cyc && pend_ok) exp_ch = pend_ch;
            check("frame_done", frame_done, (cyc == pend_cyc && pend_ok) ? 1 : 0);
            check("frame_err", frame_err, (cyc == pend_cyc && !pend_ok) ? 1 : 0);
            check("cfg_channel", cfg_channel, exp_ch);
        end
    end

    // Controller side of one frame with SCLK at 1/8 of clk; optional data change or reset.
    task automatic run_frame(input logic [5:0] cfg, input int n, input int chg_after,
                             input int chg_ch, input logic [11:0] chg_val,
                             input int rst_after, output logic [11:0] word);
        logic [11:0] exp_w;
        logic        exp_b;
        exp_w = ch[exp_ch];
        word = '0;
        @(negedge clk);
        link.din  = cfg[5];
        link.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            link.sclk = 1'b1;
            exp_b = (i < 12) ? exp_w[11-i] : 1'b0;
            check("dout_bit", link.dout, exp_b);
            if (i < 12) word[11-i] = link.dout;
            repeat (4) @(negedge clk);
            link.sclk = 1'b0;
            link.din  = (i + 1 < 6) ? cfg[4-i] : 1'b0;
            if (chg_after == i + 1) ch[chg_ch] = chg_val;
            if (rst_after == i + 1) begin
                rst_n = 1'b0;
                pend_cyc = -10;
                #1;
                check("midrst_dout", link.dout, 0);
                check("midrst_ch", cfg_channel, 0);
                link.cs_n = 1'b1;
                link.din  = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                return;
            end
            repeat (4) @(negedge clk);
        end
        link.cs_n = 1'b1;
        pend_ok  = (n >= 6) && cfg[5];
        pend_ch  = cfg[4:2];
        pend_cyc = cyc + 3;
        repeat (10) @(negedge clk);
    endtask

    logic [11:0] w;

    initial begin
        link.sclk = 1'b0;
        link.cs_n = 1'b1;
        link.din  = 1'b0;
        for (int k = 0; k < 8; k++) ch[k] = 12'($urandom);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Idle: SCLK toggling with CS_N high must do nothing
        for (int i = 0; i < 20; i++) begin
            link.sclk = 1'b1;
            repeat (4) @(negedge clk);
            link.sclk = 1'b0;
            repeat (4) @(negedge clk);
            check("idle_dout", link.dout, 0);
        end

        // Pipelined channel select
        ch[0] = 12'hA5C;
        ch[5] = 12'h3F1;
        run_frame(6'b110101, 12, 0, 0, 12'h0, 0, w);
        check("f1_word", w, 12'hA5C);
        check("f1_ch", cfg_channel, 5);
        run_frame(6'b100001, 12, 0, 0, 12'h0, 0, w);
        check("f2_word", w, 12'h3F1);
        check("f2_ch", cfg_channel, 0);

        // Aborted frame keeps the channel
        run_frame(6'b110101, 12, 0, 0, 12'h0, 0, w);
        check("f3_ch", cfg_channel, 5);
        run_frame(6'b100001, 3, 0, 0, 12'h0, 0, w);
        check("abort_ch", cfg_channel, 5);
        run_frame(6'b100001, 12, 0, 0, 12'h0, 0, w);
        check("post_abort_word", w, 12'h3F1);

        // S/D = 0 rejected
        run_frame(6'b011101, 12, 0, 0, 12'h0, 0, w);
        check("sd0_ch", cfg_channel, 0);

        // Mid-frame data change plus a 16-bit frame
        ch[0] = 12'h800;
        run_frame(6'b100001, 16, 4, 0, 12'h001, 0, w);
        check("long_word", w, 12'h800);

        // Reset mid-frame, then CH0 comes back
        run_frame(6'b110101, 12, 0, 0, 12'h0, 7, w);
        check("after_rst_ch", cfg_channel, 0);
        run_frame(6'b100001, 12, 0, 0, 12'h0, 0, w);
        check("after_rst_word", w, 12'h001);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            logic [5:0] c;
            int n;
            int chg;
            c   = 6'($urandom);
            if ($urandom_range(0, 3) != 0) c[5] = 1'b1;
            n   = $urandom_range(3, 18);
            chg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_frame(c, n, chg, $urandom_range(0, 7), 12'($urandom), 0, w);
            if ($urandom_range(0, 4) == 0) ch[$urandom_range(0, 7)] = 12'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

Serial-ADC responder: the device end of the 4-wire ADC link (ADC_SCLK, ADC_CS_N, ADC_DIN, ADC_DOUT) driven by the DigitalMicADC controller. It decodes the controller's 6-bit configuration word and shifts back 12-bit samples taken from a parallel 8-channel data bus. Uses: a drop-in ADC stand-in for closed-loop simulation, and board-to-board links where an FPGA supplies sample data to a controller. Behaviour follows the LTC2308-style pipelined protocol: each frame returns the channel addressed in the previous frame.

## Interface
- DATA_WIDTH, 12, sample width per channel
- NUM_CH, 8, channel count; the channel field is log2(NUM_CH) = 3 bits
- CFG_BITS, 6, configuration word length
- SYNC_STAGES, 2, synchronizer depth on the SCLK, CS_N and DIN pins
- CLOCK  in  1  system clock; must be at least 8× the ADC_SCLK frequency
- RESET  in  1  asynchronous, active-low reset
- CH_DATA  in  NUM_CH*DATA_WIDTH  sample values, packed with channel k at [k*12 +: 12]
- ADC_SCLK  in  1  serial clock from the controller (asynchronous to CLOCK)
- ADC_CS_N  in  1  frame select, active low
- ADC_DIN  in  1  configuration bits, MSB first
- ADC_DOUT  out  1  sample bits, MSB first
- CFG_CHANNEL  out  3  channel that the next frame will return
- FRAME_DONE  out  1  one-cycle pulse when a valid frame ends
- FRAME_ERR  out  1  one-cycle pulse when a frame is aborted or malformed

## Operation
- Pin handling:
  - SCLK, CS_N and DIN each pass through a SYNC_STAGES-flop synchronizer.
  - Synchronizer reset values: CS_N 1, SCLK 0, DIN 0.
  - Edge detection compares the synchronized value against a one-flop delayed copy.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - ADC_DOUT = 0. All SCLK edges are ignored.
  - On a CS_N falling edge: load shift_reg = CH_DATA[CFG_CHANNEL], drive ADC_DOUT = shift_reg[11], clear bit_cnt and cfg, go to SHIFT.
- SHIFT, on an SCLK rising edge:
  - If bit_cnt < CFG_BITS, shift the synchronized DIN into cfg (LSB in).
  - bit_cnt increments and saturates at 15.
- SHIFT, on an SCLK falling edge:
  - shift_reg shifts left with zero fill.
  - ADC_DOUT = the new shift_reg[11].
  - After the 12th falling edge, ADC_DOUT stays 0.
- SHIFT, on a CS_N rising edge: go to IDLE and set ADC_DOUT = 0.
  - If bit_cnt >= 6 and cfg[5] (S/D) = 1: set CFG_CHANNEL = cfg[4:2] and pulse FRAME_DONE.
  - Otherwise: leave CFG_CHANNEL unchanged and pulse FRAME_ERR.
- cfg[1] (UNI) and cfg[0] (SLP) are received and ignored.
- Sampling: the CH_DATA value is captured only at the CS_N falling edge. Changes to CH_DATA during a frame do not affect the frame.
- Simultaneous events: if a CS_N edge and an SCLK edge are detected in the same cycle, the CS_N edge wins and the SCLK edge is dropped.
- Frame length: more than 12 SCLK cycles in one frame is legal. Extra rising edges do not alter cfg; extra falling edges keep ADC_DOUT at 0.
- Reset mid-frame: all state returns to reset values immediately. A frame in progress is discarded with no FRAME_DONE or FRAME_ERR pulse.

## Timing
- Reset values:
  - ADC_DOUT 0, CFG_CHANNEL 0, FRAME_DONE 0, FRAME_ERR 0.
  - State IDLE; shift_reg, cfg and bit_cnt all 0.
- Pin-to-action latency:
  - A detected edge acts on the first CLOCK edge at which the edge flag is set.
  - Edges are detected SYNC_STAGES+1 cycles after the pin transition.
  - With the default SYNC_STAGES = 2, ADC_DOUT changes 3–4 CLOCK cycles after the pin edge.
- DOUT validity: ADC_DOUT is stable from at most 4 CLOCK cycles after an SCLK fall until the next SCLK fall. At 8× oversampling the controller therefore sees stable data at the SCLK rise.
- FRAME_DONE and FRAME_ERR:
  - Asserted for exactly one cycle, in the cycle after the CS_N rise is detected.
  - CFG_CHANNEL updates in the same cycle as FRAME_DONE.
- Throughput: back-to-back frames are legal. The CS_N high time must be at least 2 CLOCK cycles after synchronization.

## Structure
- Package adc_link_pkg holds:
  - DATA_WIDTH, NUM_CH, CFG_BITS;
  - cfg-field bit positions: SD = 5, CH_MSB = 4, CH_LSB = 2, UNI = 1, SLP = 0;
  - the state enum {IDLE, SHIFT}.
- The DigitalMicADC wrappers use the same package.
- One sub-module, adc_pin_sync, handles synchronization and edge detection. It is instantiated once per input pin, with parameter SYNC_STAGES and outputs sync, rise and fall.

## Test plan
- Reset then idle:
  - Hold RESET low, release, keep CS_N high, toggle SCLK 20 times.
  - Expect ADC_DOUT = 0, CFG_CHANNEL = 0, and no FRAME_DONE or FRAME_ERR pulses.
- Pipelined channel select:
  - Set CH0 = 0xA5C and CH5 = 0x3F1. Run frame 1 with cfg 6'b110101 (channel 5), then frame 2 with cfg 6'b100001.
  - Frame 1 returns 0xA5C. Frame 2 returns 0x3F1. CFG_CHANNEL = 5 after frame 1 and 0 after frame 2; FRAME_DONE pulses after each frame.
- Aborted frame:
  - Raise CS_N after 3 SCLK cycles, with CFG_CHANNEL = 5.
  - Expect FRAME_ERR for exactly 1 cycle, CFG_CHANNEL stays 5, and the next frame returns CH5.
- S/D = 0 frame:
  - Send cfg 6'b011101.
  - Expect FRAME_ERR and CFG_CHANNEL unchanged.
- CH_DATA changed mid-frame, plus a long frame:
  - Change CH0 from 0x800 to 0x001 after the 4th SCLK cycle, and run 16 SCLK cycles.
  - Frame returns 0x800; DOUT is 0 for bits 13–16; FRAME_DONE pulses.
- Reset mid-frame:
  - Assert RESET after 7 SCLK cycles with cfg 6'b110101 shifted in.
  - ADC_DOUT goes to 0 immediately, CFG_CHANNEL = 0, and no pulse is issued. The next full frame returns CH0.
